// File: rtl/nios_upc_pio_in_ctrl_if.sv
// Avalon-MM slave bus of the debounced input PIO controller.
// The master side drives the address and write channel; the slave side returns readdata.
interface nios_upc_pio_in_ctrl_if;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;

    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_upc_pio_in_ctrl.sv
// Debounced 8-bit input PIO: synchroniser, tick-driven debounce filter,
// edge capture with write-1-to-clear flags and a maskable level interrupt.
module nios_upc_pio_in_ctrl #(
    parameter int unsigned EDGE_TYPE  = 2,
    parameter logic [15:0] DEB_RELOAD = 16'd49999
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios_upc_pio_in_ctrl_if.slave        avs,
    input  logic [7:0]                   in_port,
    output logic                         irq
);
    localparam int unsigned NB = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 32;

    logic [NB-1:0] r_sync1, r_sync2;
    logic [NB-1:0] r_hist_a, r_hist_b;
    logic [NB-1:0] r_filt, r_filt_d;
    logic [NB-1:0] r_edge, r_mask;
    logic [CW-1:0] r_reload, r_cnt;
    logic [DW-1:0] r_rdata;
    logic          r_irq;

    logic          w_wr, w_wr_reload, w_wr_mask, w_wr_edge;
    logic          w_tick, w_bypass;
    logic [NB-1:0] w_stable, w_filt_nxt;
    logic [NB-1:0] w_rise, w_fall, w_det, w_clr;
    logic [DW-1:0] w_rdata;
    logic          w_unused;

    assign w_wr        = avs.chipselect & ~avs.write_n;
    assign w_wr_reload = w_wr && (avs.address == 2'd1);
    assign w_wr_mask   = w_wr && (avs.address == 2'd2);
    assign w_wr_edge   = w_wr && (avs.address == 2'd3);
    assign w_tick      = (r_cnt == '0);
    assign w_bypass    = (r_reload == '0);
    assign w_unused    = ^avs.writedata[DW-1:CW];

    // The 3-entry history is {sync2, hist_a, hist_b}; the filter commits on the tick that completes it.
    assign w_stable   = ~(r_sync2 ^ r_hist_a) & ~(r_hist_a ^ r_hist_b);
    assign w_filt_nxt = w_bypass ? r_sync2 :
                        w_tick   ? ((w_stable & r_sync2) | (~w_stable & r_filt)) :
                                   r_filt;

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;
    assign w_det  = (EDGE_TYPE == 0) ? w_rise :
                    (EDGE_TYPE == 1) ? w_fall :
                                       (w_rise ^ w_fall);
    assign w_clr  = w_wr_edge ? avs.writedata[NB-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        unique case (avs.address)
            2'd0: w_rdata[NB-1:0] = r_filt;
            2'd1: w_rdata[CW-1:0] = r_reload;
            2'd2: w_rdata[NB-1:0] = r_mask;
            2'd3: w_rdata[NB-1:0] = r_edge;
        endcase
    end

    // Input synchroniser and debounce filter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_hist_a <= '0;
            r_hist_b <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
        end else begin
            r_sync1  <= in_port;
            r_sync2  <= r_sync1;
            r_filt   <= w_filt_nxt;
            r_filt_d <= r_filt;
            if (w_tick) begin
                r_hist_a <= r_sync2;
                r_hist_b <= r_hist_a;
            end
        end
    end

    // Prescaler; a RELOAD write restarts the count immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= DEB_RELOAD;
            r_cnt    <= DEB_RELOAD;
        end else begin
            if (w_wr_reload) begin
                r_reload <= avs.writedata[CW-1:0];
                r_cnt    <= avs.writedata[CW-1:0];
            end else if (w_tick) begin
                r_cnt    <= r_reload;
            end else begin
                r_cnt    <= r_cnt - CW'(1);
            end
        end
    end

    // Control registers, edge capture (set beats clear), interrupt and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask  <= '0;
            r_edge  <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= avs.writedata[NB-1:0];
            end
            r_edge  <= (r_edge & ~w_clr) | w_det;
            r_irq   <= |(r_edge & r_mask);
            r_rdata <= w_rdata;
        end
    end

    assign avs.readdata = r_rdata;
    assign irq          = r_irq;
endmodule

// File: tb/tb_nios_upc_pio_in_ctrl.sv
// Bench for nios_upc_pio_in_ctrl: a behavioural model checked every cycle
// plus directed scenarios with literal expected values.
module tb_nios_upc_pio_in_ctrl;
    localparam int unsigned EDGE_TYPE = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_port;
    logic       irq;

    int n_chk = 0;
    int n_err = 0;

    nios_upc_pio_in_ctrl_if bus ();

    nios_upc_pio_in_ctrl #(
        .EDGE_TYPE  (EDGE_TYPE),
        .DEB_RELOAD (16'd49999)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: debounce expressed as a run length of equal tick samples.
    logic [7:0]  m_sync1, m_sync2, m_filt, m_filt_d, m_edge, m_mask, m_last;
    logic [15:0] m_reload, m_cnt;
    logic [31:0] m_rd;
    logic        m_irq;
    int          m_run [8];

    always @(posedge clk or negedge reset_n) begin : model
        logic       wr;
        logic [7:0] det, nf, clr;
        if (!reset_n) begin
            m_sync1 = 0; m_sync2 = 0; m_filt = 0; m_filt_d = 0;
            m_edge = 0; m_mask = 0; m_last = 0;
            m_reload = 16'd49999; m_cnt = 16'd49999;
            m_rd = 0; m_irq = 0;
            for (int b = 0; b < 8; b++) m_run[b] = 3;
        end else begin
            wr = bus.chipselect && !bus.write_n;
            case (bus.address)
                2'd0: m_rd = {24'h0, m_filt};
                2'd1: m_rd = {16'h0, m_reload};
                2'd2: m_rd = {24'h0, m_mask};
                default: m_rd = {24'h0, m_edge};
            endcase
            m_irq = |(m_edge & m_mask);
            case (EDGE_TYPE)
                0: det = m_filt & ~m_filt_d;
                1: det = ~m_filt & m_filt_d;
                default: det = m_filt ^ m_filt_d;
            endcase
            nf = m_filt;
            if (m_cnt == 0) begin
                for (int b = 0; b < 8; b++) begin
                    if (m_sync2[b] == m_last[b]) begin
                        if (m_run[b] < 3) m_run[b]++;
                    end else begin
                        m_run[b] = 1;
                        m_last[b] = m_sync2[b];
                    end
                    if (m_run[b] >= 3) nf[b] = m_last[b];
                end
            end
            if (m_reload == 0) nf = m_sync2;
            clr = (wr && bus.address == 2'd3) ? bus.writedata[7:0] : 8'h00;
            m_edge   = (m_edge & ~clr) | det;
            m_filt_d = m_filt;
            m_filt   = nf;
            if (wr && bus.address == 2'd1) m_cnt = bus.writedata[15:0];
            else if (m_cnt == 0)           m_cnt = m_reload;
            else                           m_cnt = m_cnt - 16'd1;
            if (wr && bus.address == 2'd1) m_reload = bus.writedata[15:0];
            if (wr && bus.address == 2'd2) m_mask = bus.writedata[7:0];
            m_sync2 = m_sync1;
            m_sync1 = in_port;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("model_readdata", bus.readdata, m_rd);
        chk("model_irq", 32'(irq), 32'(m_irq));
        chk("model_tick", 32'(dut.w_tick), 32'(m_cnt == 16'd0));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        cyc(1);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.address = a;
        cyc(1);
        v = bus.readdata;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] v;
        rd(2'd0, v); chk({tag, "_data"}, v, 32'h0);
        rd(2'd1, v); chk({tag, "_reload"}, v, 32'h0000C34F);
        rd(2'd2, v); chk({tag, "_mask"}, v, 32'h0);
        rd(2'd3, v); chk({tag, "_edge"}, v, 32'h0);
        chk({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        reset_n = 1'b0;
        in_port = 8'h00;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        check_reset_regs("por");

        // Bypass rising edge on bit 0
        wr(2'd1, 32'd0);
        wr(2'd2, 32'h01);
        bus.address = 2'd3;
        in_port = 8'h01;
        cyc(4);
        chk("byp_irq_k3", 32'(irq), 32'h0);
        chk("byp_edge_rd_k3", bus.readdata, 32'h0);
        cyc(1);
        chk("byp_irq_k4", 32'(irq), 32'h1);
        chk("byp_edge_rd_k4", bus.readdata, 32'h01);
        rd(2'd0, v); chk("byp_data", v, 32'h01);

        // W1C race: set on bit 0 coincides with clearing bits 1:0
        wr(2'd3, 32'hFF);
        in_port = 8'h03; cyc(5);
        in_port = 8'h02; cyc(5);
        rd(2'd3, v); chk("race_pre_edge", v, 32'h03);
        in_port = 8'h03;
        cyc(3);
        bus.address = 2'd3; bus.writedata = 32'h03; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        cyc(1);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        chk("race_irq_a", 32'(irq), 32'h1);
        cyc(1);
        chk("race_irq_b", 32'(irq), 32'h1);
        rd(2'd3, v); chk("race_edge", v, 32'h01);

        // Mask gating and clear on bit 7
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h00);
        in_port = 8'h83; cyc(5);
        rd(2'd3, v); chk("mask_edge", v, 32'h80);
        chk("mask_off_irq", 32'(irq), 32'h0);
        wr(2'd2, 32'h80);
        chk("mask_wr_irq_0", 32'(irq), 32'h0);
        cyc(1);
        chk("mask_wr_irq_1", 32'(irq), 32'h1);
        wr(2'd3, 32'h80);
        chk("clr_irq_0", 32'(irq), 32'h1);
        cyc(1);
        chk("clr_irq_1", 32'(irq), 32'h0);

        // Glitch rejection with RELOAD=3
        wr(2'd1, 32'd3);
        wr(2'd3, 32'hFF);
        in_port = 8'h87; cyc(3);
        in_port = 8'h83; cyc(20);
        rd(2'd0, v); chk("glitch_data", v, 32'h83);
        rd(2'd3, v); chk("glitch_edge", v, 32'h00);
        in_port = 8'h87; cyc(14);
        rd(2'd0, v); chk("hold_data", v, 32'h87);
        rd(2'd3, v); chk("hold_edge", v, 32'h04);

        // Reload restart mid-count, then a falling filtered edge
        cyc(1);
        wr(2'd1, 32'd5);
        for (int i = 0; i < 6; i++) begin
            chk("reload_tick", 32'(dut.w_tick), 32'(i == 5));
            cyc(1);
        end
        wr(2'd3, 32'hFF);
        in_port = 8'h83; cyc(30);
        rd(2'd0, v); chk("fall_data", v, 32'h83);
        rd(2'd3, v); chk("fall_edge", v, 32'h04);
        chk("fall_irq", 32'(irq), 32'h0);

        // Asynchronous reset in the middle of a debounce
        in_port = 8'h93; cyc(7);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_rd", bus.readdata, 32'h0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        check_reset_regs("midrst");

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/nios_upc_pio_in_ctrl.md
# nios_upc_pio_in_ctrl

Avalon-MM input-port controller for the 8-bit push-button/switch PIO of the Nios II system. Synchronises and debounces `in_port`, detects edges, latches them in a write-1-to-clear capture register and drives a maskable level interrupt to the CPU. It sits on the data master's peripheral bus in place of a plain read-only input PIO.

## Interface
- `EDGE_TYPE`, 2: captured edge; 0 = rising, 1 = falling, 2 = any.
- `DEB_RELOAD`, 16'd49999: reset value of the debounce reload register (1 ms tick at 50 MHz).

- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word offset of the register.
- `chipselect`  in  1  slave select; qualifies writes only.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  8  raw asynchronous inputs.
- `readdata`  out  32  registered read data.
- `irq`  out  1  registered level interrupt.

## Operation
- Register map:
  - Offset 0, DATA: RO. Bits [7:0] hold the debounced inputs.
  - Offset 1, RELOAD: RW. Bits [15:0] hold the debounce prescaler reload value.
  - Offset 2, MASK: RW. Bits [7:0] are the per-bit IRQ enables.
  - Offset 3, EDGE: R/W1C. Bits [7:0] are the edge-capture flags.
  - Unused read bits are 0.
- Write occurs when `chipselect`=1 and `write_n`=0, on the rising clock edge.
- Synchroniser: each `in_port` bit passes through a 2-flop chain (`sync1`, `sync2`).
- Prescaler: a 16-bit down-counter.
  - At 0 it asserts `tick` for one cycle and reloads RELOAD. Tick period is RELOAD+1 cycles.
  - Any write to RELOAD loads the new value into the counter in the same cycle.
- Debounce, per bit: a 3-deep history shifts in `sync2` on each `tick`.
  - The filtered bit takes the history value when all 3 entries are equal; otherwise it holds.
  - If RELOAD = 0, bypass mode applies: filtered <= `sync2` every cycle and the history is ignored.
- Edge detect: `filt_d` <= filtered every cycle.
  - Rising = filtered & ~`filt_d`.
  - Falling = ~filtered & `filt_d`.
  - Any = the XOR of the two.
- EDGE register, per bit:
  - Set on a detected edge.
  - Cleared by writing 1 to offset 3.
  - If set and clear occur in the same cycle, set wins.
- `irq` <= |(EDGE & MASK).
- `readdata` <= mux(address) every cycle. There is no chipselect qualification on read.

## Timing
- Reset values:
  - `readdata` = 0 and `irq` = 0.
  - `sync1`, `sync2`, history, filtered and `filt_d` = 0.
  - EDGE = 0 and MASK = 0.
  - RELOAD = `DEB_RELOAD`; prescaler counter = `DEB_RELOAD`.
- Read latency: 1 cycle. `readdata` reflects the register state at the preceding edge.
- Bypass-mode latency, with `in_port` changing before edge k:
  - `sync2` valid at k+1, filtered at k+2.
  - EDGE bit set at k+3.
  - `irq` high at k+4 if the bit is masked in.
- Debounce mode: filtered updates on the 3rd consecutive `tick` with an equal sample, i.e. 2 full tick periods after the first matching sample. A glitch shorter than one tick period never reaches filtered.
- MASK write takes effect on `irq` one cycle after the write edge. Same for an EDGE clear.
- Prescaler wrap: 0 → RELOAD; `tick` is asserted in the cycle the count is 0.
- Reset mid-debounce: all state returns to reset values immediately and asynchronously; no edge is reported for inputs already high after reset until they are filtered (a rising edge is then captured).

## Test plan
- Reset check: assert `reset_n`=0 mid-run, then read all 4 offsets. Required values:
  - DATA 0, RELOAD 0x0000C34F, MASK 0, EDGE 0.
  - `irq` 0.
- Bypass rising edge (RELOAD=0, MASK=0x01, EDGE_TYPE=0): set `in_port`=0x01 before edge k.
  - EDGE=0x01 at k+3; `irq`=1 at k+4.
  - DATA read returns 0x01.
- Glitch rejection (RELOAD=3): pulse `in_port`[2] for 3 cycles. Required: DATA stays 0, EDGE stays 0.
  - Then hold it high for 20 cycles. Required: DATA=0x04 after ≤12 cycles beyond sync, and EDGE[2]=1.
- W1C race: with EDGE=0x03, write 0x03 to offset 3 in the same cycle a new edge on bit 0 is detected. Required: EDGE=0x01, and `irq` stays 1 with MASK=0x01.
- Mask gating: with EDGE=0x80 and MASK=0x00, `irq`=0. Write MASK=0x80 → `irq`=1 one cycle later. Write 0x80 to offset 3 → `irq`=0 one cycle later.
- Any-edge with reload restart (EDGE_TYPE=2):
  - Write RELOAD=5 mid-count; required next `tick` exactly 6 cycles after the write.
  - A 1→0 filtered transition sets the EDGE bit.
